// File: rtl/seq_serializer_if.sv
// Handshake and serial-output bundle between an upstream word source and seq_serializer.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             word_done;

    modport master (
        output data_in, load_valid,
        input  load_ready, dout, dout_valid, busy, word_done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, dout, dout_valid, busy, word_done
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words out MSB first, then GAP idle cycles.
// Define SER_HOLD_EN to add a one-word holding register so words stream without a bubble.
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input logic             clk,
    input logic             rst,
    seq_serializer_if.slave bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
    localparam logic [7:0]       LAST_GAP = 8'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       gap_cnt;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             word_done;

    logic             accept;
    logic             word_end;
    logic             gap_end;
    logic             free;
    logic             load_en;
    logic [WIDTH-1:0] load_word;

`ifdef SER_HOLD_EN
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic             hold_wr;
    logic             hold_take;

    assign bus.load_ready = ~hold_full;
`else
    assign bus.load_ready = (state == IDLE);
`endif

    assign accept   = bus.load_valid & bus.load_ready;
    assign word_end = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign gap_end  = (state == GAP_WAIT) && (gap_cnt == LAST_GAP);
    // Shifter can take a new word on this edge: idle, or its current word/gap finishes now.
    assign free     = (state == IDLE) || (word_end && (GAP == 0)) || gap_end;

    always_comb begin
        load_en   = 1'b0;
        load_word = bus.data_in;
`ifdef SER_HOLD_EN
        hold_wr   = 1'b0;
        hold_take = 1'b0;
        if (free && hold_full) begin
            load_en   = 1'b1;
            load_word = hold_reg;
            hold_take = 1'b1;
            hold_wr   = accept;
        end else if (free && accept) begin
            load_en = 1'b1;
        end else if (accept) begin
            hold_wr = 1'b1;
        end
`else
        load_en = free && accept;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            word_done  <= 1'b0;
`ifdef SER_HOLD_EN
            hold_reg   <= '0;
            hold_full  <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            case (state)
                SHIFT: begin
                    if (!word_end) begin
                        dout      <= shreg[WIDTH-1];
                        shreg     <= shreg << 1;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        word_done <= (bit_cnt == PRE_LAST);
                    end else if (GAP > 0) begin
                        state      <= GAP_WAIT;
                        gap_cnt    <= '0;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                    end
                end
                GAP_WAIT: gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase

            if (free) begin
                state      <= IDLE;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                busy       <= 1'b0;
            end

            // A new word's MSB is on dout the cycle after it is loaded.
            if (load_en) begin
                state      <= SHIFT;
                shreg      <= load_word << 1;
                dout       <= load_word[WIDTH-1];
                dout_valid <= 1'b1;
                busy       <= 1'b1;
                bit_cnt    <= '0;
            end

`ifdef SER_HOLD_EN
            if (hold_wr) begin
                hold_reg  <= bus.data_in;
                hold_full <= 1'b1;
            end else if (hold_take) begin
                hold_full <= 1'b0;
            end
`endif
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.busy       = busy;
    assign bus.word_done  = word_done;
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: a GAP=0 and a GAP=3 instance checked each cycle against a word-timeline model.
module tb_seq_serializer;
    localparam int W = 8;
`ifdef SER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         lv [2];
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    int           t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_serializer_if #(.WIDTH(W)) bus0 ();
    seq_serializer_if #(.WIDTH(W)) bus1 ();

    assign bus0.data_in    = data_in;
    assign bus0.load_valid = lv[0];
    assign bus1.data_in    = data_in;
    assign bus1.load_valid = lv[1];

    seq_serializer #(.WIDTH(W), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_serializer #(.WIDTH(W), .GAP(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // {load_ready, dout, dout_valid, busy, word_done}
    logic [4:0] act [2];
    assign act[0] = {bus0.load_ready, bus0.dout, bus0.dout_valid, bus0.busy, bus0.word_done};
    assign act[1] = {bus1.load_ready, bus1.dout, bus1.dout_valid, bus1.busy, bus1.word_done};

    // Model: each word occupies [start, start+W-1] for bits, then gap cycles up to 'until'.
    int           m_start [2] = '{0, 0};
    int           m_until [2] = '{-1, -1};
    int           m_acc   [2] = '{0, 0};
    logic [W-1:0] m_word  [2];
    logic [W-1:0] m_hw    [2];
    bit           m_hv    [2] = '{1'b0, 1'b0};

    function automatic int gap_of(int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic bit exp_ready(int i, int c);
        if (HOLD) return !m_hv[i];
        return c > m_until[i];
    endfunction

    function automatic logic [4:0] expected(int i, int c);
        bit   act_c;
        bit   inw;
        int   k;
        logic b;
        act_c = (c >= m_start[i]) && (c <= m_until[i]);
        inw   = act_c && (c <= m_start[i] + W - 1);
        k     = c - m_start[i];
        b     = 1'b0;
        if (inw) b = m_word[i][W-1-k];
        return {exp_ready(i, c), b, inw, act_c, inw && (k == W - 1)};
    endfunction

    task automatic begin_word(int i, logic [W-1:0] w, int s);
        m_word[i]  = w;
        m_start[i] = s;
        m_until[i] = s + W - 1 + gap_of(i);
    endtask

    task automatic model_step(int i, int c);
        bit acc;
        bit free;
        if (rst) begin
            m_start[i] = c + 1;
            m_until[i] = c;
            m_hv[i]    = 1'b0;
            return;
        end
        acc  = lv[i] && exp_ready(i, c);
        free = c >= m_until[i];
        if (acc) m_acc[i]++;
        if (HOLD && free && m_hv[i]) begin
            begin_word(i, m_hw[i], c + 1);
            if (acc) m_hw[i] = data_in;
            else     m_hv[i] = 1'b0;
        end else if (free && acc) begin
            begin_word(i, data_in, c + 1);
        end else if (acc) begin
            m_hw[i] = data_in;
            m_hv[i] = 1'b1;
        end
    endtask

    // Observed words, reassembled from the serial stream.
    logic [W-1:0] o_sh  [2];
    int           o_cnt [2] = '{0, 0};
    int           o_st  [2] = '{0, 0};
    int           o_n   [2] = '{0, 0};
    logic [W-1:0] obs_w [2][16];
    int           obs_s [2][16];
    int           obs_e [2][16];

    task automatic observe(int i);
        if (rst) begin
            o_cnt[i] = 0;
            return;
        end
        if (act[i][2] === 1'b1) begin
            if (o_cnt[i] == 0) o_st[i] = cyc;
            o_sh[i] = {o_sh[i][W-2:0], act[i][3]};
            o_cnt[i]++;
        end
        if (act[i][0] === 1'b1 && o_n[i] < 16) begin
            obs_w[i][o_n[i]] = o_sh[i];
            obs_s[i][o_n[i]] = o_st[i];
            obs_e[i][o_n[i]] = cyc;
            o_n[i]++;
            o_cnt[i] = 0;
        end
    endtask

    function automatic string sig_name(int b);
        case (b)
            4:       return "load_ready";
            3:       return "dout";
            2:       return "dout_valid";
            1:       return "busy";
            default: return "word_done";
        endcase
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                logic [4:0] e;
                e = expected(i, cyc);
                for (int b = 0; b < 5; b++) begin
                    tests++;
                    if (act[i][b] !== e[b]) begin
                        fails++;
                        $display("FAIL %s[%0d] cycle %0d: got %b, expected %b",
                                 sig_name(b), i, cyc, act[i][b], e[b]);
                    end
                end
                observe(i);
                model_step(i, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    task automatic offer(input logic [W-1:0] w);
        int tgt0;
        int tgt1;
        tgt0    = m_acc[0] + 1;
        tgt1    = m_acc[1] + 1;
        data_in = w;
        for (int k = 0; k < 60; k++) begin
            lv[0] = (m_acc[0] < tgt0);
            lv[1] = (m_acc[1] < tgt1);
            if (!lv[0] && !lv[1]) break;
            tick();
        end
        chk("offer_accepted", (m_acc[0] >= tgt0) && (m_acc[1] >= tgt1), 1);
        lv[0] = 1'b0;
        lv[1] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        lv[0] = 1'b0;
        lv[1] = 1'b0;
        rst   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", bus0.load_ready, 1);
        chk("rst_dout", bus0.dout, 0);
        chk("rst_busy", bus1.busy, 0);

        // Single word: bits on t0+1..t0+8, word_done on the LSB
        t0 = cyc;
        offer(8'hD3);
        repeat (20) tick();
        chk("t1_count", o_n[0], 1);
        chk("t1_word", obs_w[0][0], 8'hD3);
        chk("t1_first_bit", obs_s[0][0] - t0, 1);
        chk("t1_done_cycle", obs_e[0][0] - t0, 8);
        chk("t1_gap_inst_word", obs_w[1][0], 8'hD3);

        // Back-to-back words with load_valid held high
        offer(8'hD3);
        offer(8'hD3);
        repeat (30) tick();
        chk("t2_word_a", obs_w[0][1], 8'hD3);
        chk("t2_word_b", obs_w[0][2], 8'hD3);
        chk("t2_bubble_gap0", obs_s[0][2] - obs_e[0][1] - 1, HOLD ? 0 : 1);
        chk("t4_bubble_gap3", obs_s[1][2] - obs_e[1][1] - 1, HOLD ? 3 : 4);
        chk("t4_word_b", obs_w[1][2], 8'hD3);

        // Reset on the fourth bit of 8'hFF abandons the word
        offer(8'hFF);
        while (cyc < m_start[0] + 3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_dout", bus0.dout, 0);
        chk("t5_valid", bus0.dout_valid, 0);
        chk("t5_busy", bus0.busy, 0);
        chk("t5_ready", bus0.load_ready, 1);
        chk("t5_ready_gap3", bus1.load_ready, 1);
        repeat (5) tick();
        chk("t5_no_done", o_n[0], 3);

        // load_valid toggled and data_in churned while not ready
        offer(8'hA5);
        offer(8'h3C);
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 2; i++)
                lv[i] = exp_ready(i, cyc) ? 1'b0 : k[0];
            data_in = W'($urandom);
            tick();
        end
        lv[0] = 1'b0;
        lv[1] = 1'b0;
        repeat (30) tick();
        chk("t6_count", o_n[0], 5);
        chk("t6_word_a", obs_w[0][3], 8'hA5);
        chk("t6_word_b", obs_w[0][4], 8'h3C);
        chk("t6_count_gap3", o_n[1], 5);
        chk("t6_word_b_gap3", obs_w[1][4], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
